// File: rtl/traffic_light_controller_param.sv
// Two-way intersection controller with tick-based phase timing, pedestrian
// walk phase, gap-out with guaranteed minimum green, and flashing night mode.
// Lamp and walk outputs are registered and always reflect the current state.
module traffic_light_controller_param #(
  parameter int CNT_W       = 8,
  parameter int GREEN_T     = 10,
  parameter int MIN_GREEN_T = 4,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int PED_T       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ns_sensor,
  input  logic             ew_sensor,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_ALL_RED   = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_PED_WALK  = 3'd5,
    ST_FLASH     = 3'd6
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_T);
  // cnt at or below this value means at least MIN_GREEN_T ticks have elapsed
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GREEN_T - MIN_GREEN_T);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

  // Reject illegal timing parameters at elaboration
  if (!(GREEN_T >= 1 && MIN_GREEN_T >= 1 && YELLOW_T >= 1 && ALLRED_T >= 1 &&
        PED_T >= 1 && MIN_GREEN_T <= GREEN_T && CNT_W >= 1 && CNT_W <= 31 &&
        GREEN_T < (1 << CNT_W) && YELLOW_T < (1 << CNT_W) &&
        ALLRED_T < (1 << CNT_W) && PED_T < (1 << CNT_W))) begin : g_bad_params
    $error("traffic_light_controller_param: illegal timing parameters");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             flash_phase_q, flash_phase_d;
  logic [2:0]       ns_light_q, ns_light_d;
  logic [2:0]       ew_light_q, ew_light_d;
  logic             walk_q, walk_d;

  logic exit_s;
  logic gap_ok_s;
  logic enter_ped_s;
  logic illegal_s;

  // Next-state, counter and direction bookkeeping
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    next_dir_d    = next_dir_q;
    flash_phase_d = flash_phase_q;
    enter_ped_s   = 1'b0;
    illegal_s     = 1'b0;
    exit_s        = (cnt_q <= ONE_C);
    gap_ok_s      = (cnt_q <= GAP_C);

    case (state_q)
      ST_ALL_RED: begin
        if (tick) begin
          if (exit_s) begin
            if (flash_mode) begin
              state_d       = ST_FLASH;
              cnt_d         = ZERO_C;
              flash_phase_d = 1'b0;
            end else if (ped_pending_q) begin
              state_d     = ST_PED_WALK;
              cnt_d       = PED_C;
              enter_ped_s = 1'b1;
            end else if (next_dir_q == DIR_NS) begin
              state_d = ST_NS_GREEN;
              cnt_d   = GREEN_C;
            end else begin
              state_d = ST_EW_GREEN;
              cnt_d   = GREEN_C;
            end
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_NS_GREEN: begin
        if (tick) begin
          if (exit_s || (gap_ok_s && ((ew_sensor && !ns_sensor) || ped_pending_q))) begin
            state_d    = ST_NS_YELLOW;
            cnt_d      = YELLOW_C;
            next_dir_d = DIR_EW;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_EW_GREEN: begin
        if (tick) begin
          if (exit_s || (gap_ok_s && ((ns_sensor && !ew_sensor) || ped_pending_q))) begin
            state_d    = ST_EW_YELLOW;
            cnt_d      = YELLOW_C;
            next_dir_d = DIR_NS;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_NS_YELLOW, ST_EW_YELLOW, ST_PED_WALK: begin
        if (tick) begin
          if (exit_s) begin
            state_d = ST_ALL_RED;
            cnt_d   = ALLRED_C;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FLASH: begin
        if (tick) begin
          flash_phase_d = ~flash_phase_q;
          if (!flash_mode) begin
            state_d    = ST_ALL_RED;
            cnt_d      = ALLRED_C;
            next_dir_d = DIR_NS;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          flash_phase_d = flash_phase_q;
        end
      end
      default: begin
        illegal_s     = 1'b1;
        state_d       = ST_ALL_RED;
        cnt_d         = ALLRED_C;
        next_dir_d    = DIR_NS;
        flash_phase_d = 1'b0;
      end
    endcase
  end

  // Pedestrian latch: entry to the walk phase wins over a same-clk request
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (illegal_s || enter_ped_s) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != ST_PED_WALK)) begin
      ped_pending_d = 1'b1;
    end else begin
      ped_pending_d = ped_pending_q;
    end
  end

  // Moore lamp decode of the upcoming state, registered alongside it
  always_comb begin
    ns_light_d = LAMP_RED;
    ew_light_d = LAMP_RED;
    walk_d     = 1'b0;
    case (state_d)
      ST_NS_GREEN:  ns_light_d = LAMP_GREEN;
      ST_NS_YELLOW: ns_light_d = LAMP_YELLOW;
      ST_EW_GREEN:  ew_light_d = LAMP_GREEN;
      ST_EW_YELLOW: ew_light_d = LAMP_YELLOW;
      ST_PED_WALK:  walk_d     = 1'b1;
      ST_FLASH: begin
        ns_light_d = flash_phase_d ? LAMP_YELLOW : LAMP_OFF;
        ew_light_d = flash_phase_d ? LAMP_RED    : LAMP_OFF;
      end
      default: begin
        ns_light_d = LAMP_RED;
        ew_light_d = LAMP_RED;
        walk_d     = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ALL_RED;
      cnt_q         <= ALLRED_C;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      flash_phase_q <= 1'b0;
      ns_light_q    <= LAMP_RED;
      ew_light_q    <= LAMP_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      flash_phase_q <= flash_phase_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign cnt      = cnt_q;
  assign state    = state_q;

endmodule
